sw_arb_2: RTL and testbench

Packet-granular (wormhole) arbiter for the 2:1 output mux of the router output stage. It watches flit valid and type on both mux inputs and drives the mux `sel` one-hot. It locks the grant from a HEAD flit until the matching TAIL flit has transferred, then rotates priority round-robin. It returns per-input ready so the losing input stalls. A per-packet flit counter flags runaway packets that never send a TAIL.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/sw_arb_2.sv | 164 ++++++++++++++++
 tb/tb_sw_arb_2.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg: shared definitions for the router output stage.
//   - flit_type_e : flit type field encodings (NONE/HEAD/DATA/TAIL)
//   - arb_state_e : output arbiter lock state (IDLE/LOCK0/LOCK1)
//   - PORTW       : width of the output mux one-hot select
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int PORTW = 5;

  typedef enum logic [1:0] {
    FLIT_NONE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_DATA = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2: combinational 2-request round-robin chooser.
//   i_req[1:0] : request per input
//   i_rr       : priority pointer, index that wins when both request
//   o_gnt      : granted input index (meaningful only when o_valid=1)
//   o_valid    : at least one request present
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic       o_gnt,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    // With a single requester it wins outright; the pointer only breaks ties.
    o_gnt   = (&i_req) ? i_rr : i_req[1];
  end

endmodule

// File: rtl/sw_arb_2.sv
// -----------------------------------------------------------------------------
// sw_arb_2: packet-granular (wormhole) arbiter for a 2:1 output mux.
// A HEAD flit wins the output and holds it until its TAIL transfers; ties
// between simultaneous HEADs are broken by a round-robin pointer. A per-packet
// flit counter catches packets that never send a TAIL.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ivalid_0, itype_0   : input 0 flit valid / type
//   ivalid_1, itype_1   : input 1 flit valid / type
//   oready              : downstream accepts a flit this cycle
//   sel                 : registered one-hot mux select (bit n = input n)
//   iready_0, iready_1  : input n flit consumed this cycle
//   err                 : sticky packet-length overflow / protocol violation
// -----------------------------------------------------------------------------
module sw_arb_2
  import noc_pkg::*;
#(
  parameter int PORTW   = noc_pkg::PORTW,
  parameter int TYPEW   = 2,
  parameter int MAX_LEN = 64,
  parameter int CNTW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             oready,
  output logic [PORTW-1:0] sel,
  output logic             iready_0,
  output logic             iready_1,
  output logic             err
);

  localparam logic [TYPEW-1:0] L_NONE = TYPEW'(FLIT_NONE);
  localparam logic [TYPEW-1:0] L_HEAD = TYPEW'(FLIT_HEAD);
  localparam logic [TYPEW-1:0] L_TAIL = TYPEW'(FLIT_TAIL);
  localparam logic [CNTW-1:0]  L_MAX  = CNTW'(MAX_LEN);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic             r_rr;
  logic             w_rr_next;
  logic [CNTW-1:0]  r_cnt;
  logic [CNTW-1:0]  w_cnt_next;
  logic [CNTW-1:0]  w_cnt_inc;
  logic             r_err;
  logic             w_err_next;
  logic [PORTW-1:0] r_sel;
  logic [PORTW-1:0] w_sel_next;

  logic [1:0]       w_req;
  logic             w_pick;
  logic             w_pick_valid;
  logic             w_own_idx;
  logic             w_other;
  logic             w_own_xfer;
  logic [TYPEW-1:0] w_own_type;

  assign w_req[0] = ivalid_0 & (itype_0 == L_HEAD);
  assign w_req[1] = ivalid_1 & (itype_1 == L_HEAD);

  rr_pick2 u_pick (
    .i_req   (w_req),
    .i_rr    (r_rr),
    .o_gnt   (w_pick),
    .o_valid (w_pick_valid)
  );

  // Ready is a pure function of the lock state and downstream ready, so a
  // losing input stalls without any extra pipeline stage.
  assign iready_0 = (r_state == LOCK0) & oready;
  assign iready_1 = (r_state == LOCK1) & oready;

  assign w_own_idx  = (r_state == LOCK1);
  assign w_other    = ~w_own_idx;
  assign w_own_type = w_own_idx ? itype_1 : itype_0;
  assign w_own_xfer = (iready_0 & ivalid_0) | (iready_1 & ivalid_1);
  assign w_cnt_inc  = r_cnt + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_rr_next    = r_rr;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;

    unique case (r_state)
      IDLE: begin
        // Grant also waits on oready: a stalled output freezes the arbiter.
        if (oready && w_pick_valid) begin
          w_next_state = w_pick ? LOCK1 : LOCK0;
          w_cnt_next   = '0;
        end
      end

      LOCK0, LOCK1: begin
        if (w_own_xfer) begin
          w_cnt_next = w_cnt_inc;
          if (w_own_type == L_TAIL) begin
            w_rr_next = w_other;
            // Hand over straight to a waiting HEAD so back-to-back packets
            // see no idle bubble.
            if (w_req[w_other]) begin
              w_next_state = w_other ? LOCK1 : LOCK0;
              w_cnt_next   = '0;
            end else begin
              w_next_state = IDLE;
            end
          end else begin
            // The packet's own HEAD transfers with the counter at zero; any
            // later HEAD, or a NONE flit, is a protocol violation. The flit
            // is still counted and the lock is kept.
            if ((w_own_type == L_NONE) ||
                ((w_own_type == L_HEAD) && (r_cnt != '0))) begin
              w_err_next = 1'b1;
            end
            if (w_cnt_inc == L_MAX) begin
              w_err_next   = 1'b1;
              w_next_state = IDLE;
              w_rr_next    = w_other;
            end
          end
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_sel_next = '0;
    case (w_next_state)
      LOCK0:   w_sel_next[0] = 1'b1;
      LOCK1:   w_sel_next[1] = 1'b1;
      default: w_sel_next = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next_state;
      r_rr    <= w_rr_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_sel   <= w_sel_next;
    end
  end

  assign sel = r_sel;
  assign err = r_err;

endmodule

// File: tb/tb_sw_arb_2.sv
// -----------------------------------------------------------------------------
// tb_sw_arb_2: scoreboard bench for sw_arb_2. Stimulus pushes per-port source
// flits and, in the hand-computed transfer order, the expected transfers; a
// negedge monitor pops and compares each transfer the DUT performs. Cycle
// specific values (sel timing, err, ready) are compared by the stimulus.
// -----------------------------------------------------------------------------
module tb_sw_arb_2;
  import noc_pkg::*;

  typedef struct {
    int         port;
    logic [1:0] ty;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ivalid_0, ivalid_1;
  logic [1:0] itype_0, itype_1;
  logic       oready;
  logic [4:0] sel;
  logic       iready_0, iready_1;
  logic       err;

  exp_t       exp_q[$];
  logic [1:0] src0[$];
  logic [1:0] src1[$];
  int         total = 0;
  int         bad   = 0;
  int         n_xfer = 0;
  bit         x0_s = 1'b0;
  bit         x1_s = 1'b0;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  sw_arb_2 #(.PORTW(5), .TYPEW(2), .MAX_LEN(64), .CNTW(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .ivalid_0 (ivalid_0),
    .itype_0  (itype_0),
    .ivalid_1 (ivalid_1),
    .itype_1  (itype_1),
    .oready   (oready),
    .sel      (sel),
    .iready_0 (iready_0),
    .iready_1 (iready_1),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic score(input int p, input logic [1:0] ty);
    exp_t e;
    n_xfer++;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL xfer_unexpected: got port %0d type %0d, expected no transfer", p, ty);
    end else begin
      e = exp_q.pop_front();
      check("xfer_port", p, e.port);
      check("xfer_type", {30'd0, ty}, {30'd0, e.ty});
      check("xfer_sel", {27'd0, sel}, (e.port == 1) ? 32'h2 : 32'h1);
    end
  endtask

  // Monitor: a transfer is ivalid & iready, sampled mid-cycle.
  always @(negedge clk) begin
    x0_s = ivalid_0 & iready_0;
    x1_s = ivalid_1 & iready_1;
    if (!rst) begin
      if (x0_s) score(0, itype_0);
      if (x1_s) score(1, itype_1);
    end
  end

  task automatic drive();
    ivalid_0 = (src0.size() > 0);
    itype_0  = ivalid_0 ? src0[0] : T_NONE;
    ivalid_1 = (src1.size() > 0);
    itype_1  = ivalid_1 ? src1[0] : T_NONE;
  endtask

  // Advance one cycle: retire flits that transferred, present the next ones.
  task automatic step();
    @(posedge clk);
    #1;
    if (x0_s && src0.size() > 0) src0.delete(0);
    if (x1_s && src1.size() > 0) src1.delete(0);
    drive();
  endtask

  task automatic add(input int p, input logic [1:0] ty, input bit expect_it);
    exp_t e;
    if (p == 0) src0.push_back(ty);
    else        src1.push_back(ty);
    if (expect_it) begin
      e.port = p;
      e.ty   = ty;
      exp_q.push_back(e);
    end
  endtask

  task automatic pkt(input int p, input int ndata);
    add(p, T_HEAD, 1'b1);
    for (int i = 0; i < ndata; i++) add(p, T_DATA, 1'b1);
    add(p, T_TAIL, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d flits left, expected 0", name, exp_q.size());
    end
    step();
  endtask

  initial begin
    int n0;
    rst    = 1'b1;
    oready = 1'b0;
    drive();
    #1;
    check("rst_sel", {27'd0, sel}, 32'h0);
    check("rst_iready0", {31'd0, iready_0}, 32'h0);
    check("rst_iready1", {31'd0, iready_1}, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    oready = 1'b1;
    step();

    // 1: single packet on input 1, HEAD + 20 DATA + TAIL.
    n0 = n_xfer;
    pkt(1, 20);
    drive();
    check("t1_sel_idle", {27'd0, sel}, 32'h0);
    step();
    check("t1_sel_grant", {27'd0, sel}, 32'h2);
    for (int i = 0; i < 21; i++) begin
      step();
      check("t1_sel_hold", {27'd0, sel}, 32'h2);
    end
    step();
    check("t1_sel_release", {27'd0, sel}, 32'h0);
    check("t1_xfers", n_xfer - n0, 32'd22);
    check("t1_err", {31'd0, err}, 32'h0);

    // 2: simultaneous HEADs with rr=0: port 0 first, no bubble on handover.
    pkt(0, 2);
    pkt(1, 2);
    drive();
    step();
    check("t2_sel_p0", {27'd0, sel}, 32'h1);
    repeat (3) step();
    check("t2_sel_p0_tail", {27'd0, sel}, 32'h1);
    step();
    check("t2_sel_handover", {27'd0, sel}, 32'h2);
    drain("t2a");
    check("t2_sel_idle", {27'd0, sel}, 32'h0);
    // A lone port 0 packet leaves rr pointing at port 1.
    pkt(0, 1);
    drive();
    drain("t2b");
    pkt(1, 1);
    pkt(0, 1);
    drive();
    step();
    check("t2_sel_p1_first", {27'd0, sel}, 32'h2);
    drain("t2c");

    // 3: oready low for 3 cycles mid-packet.
    n0 = n_xfer;
    pkt(0, 20);
    drive();
    repeat (5) step();
    oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_iready0", {31'd0, iready_0}, 32'h0);
      check("t3_sel", {27'd0, sel}, 32'h1);
      check("t3_cnt", {25'd0, dut.r_cnt}, 32'd4);
      check("t3_xfers_frozen", n_xfer - n0, 32'd4);
      step();
    end
    oready = 1'b1;
    drain("t3");
    check("t3_xfers", n_xfer - n0, 32'd22);
    check("t3_err", {31'd0, err}, 32'h0);

    // 4: 64 non-TAIL flits on port 0, port 1 HEAD pending.
    add(0, T_HEAD, 1'b1);
    for (int i = 0; i < 63; i++) add(0, T_DATA, 1'b1);
    drive();
    step();
    check("t4_sel_p0", {27'd0, sel}, 32'h1);
    pkt(1, 1);
    drive();
    repeat (63) step();
    check("t4_err_before", {31'd0, err}, 32'h0);
    check("t4_sel_before", {27'd0, sel}, 32'h1);
    step();
    check("t4_err_after", {31'd0, err}, 32'h1);
    check("t4_sel_idle", {27'd0, sel}, 32'h0);
    step();
    check("t4_sel_p1", {27'd0, sel}, 32'h2);
    drain("t4");

    // 5: asynchronous reset mid-packet.
    pkt(0, 10);
    drive();
    repeat (4) step();
    check("t5_sel_locked", {27'd0, sel}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_sel_async", {27'd0, sel}, 32'h0);
    check("t5_iready0_async", {31'd0, iready_0}, 32'h0);
    check("t5_err_async", {31'd0, err}, 32'h0);
    exp_q.delete();
    step();
    check("t5_sel_in_rst", {27'd0, sel}, 32'h0);
    rst = 1'b0;
    step();
    check("t5_sel_stale_data", {27'd0, sel}, 32'h0);
    src0.delete();
    pkt(0, 1);
    drive();
    step();
    check("t5_sel_regrant", {27'd0, sel}, 32'h1);
    drain("t5");
    check("t5_err", {31'd0, err}, 32'h0);

    // 6: TAIL (port 1) and DATA (port 0) while idle are not consumed.
    add(1, T_TAIL, 1'b0);
    add(0, T_DATA, 1'b0);
    drive();
    for (int i = 0; i < 4; i++) begin
      check("t6_iready1", {31'd0, iready_1}, 32'h0);
      check("t6_iready0", {31'd0, iready_0}, 32'h0);
      check("t6_sel", {27'd0, sel}, 32'h0);
      check("t6_err", {31'd0, err}, 32'h0);
      step();
    end
    src0.delete();
    src1.delete();
    drive();
    step();

    // 7: repeated HEAD inside a packet flags err but keeps the lock.
    add(0, T_HEAD, 1'b1);
    add(0, T_HEAD, 1'b1);
    add(0, T_TAIL, 1'b1);
    drive();
    step();
    check("t7_err_first_head", {31'd0, err}, 32'h0);
    step();
    check("t7_err_pending", {31'd0, err}, 32'h0);
    step();
    check("t7_err_set", {31'd0, err}, 32'h1);
    check("t7_sel_kept", {27'd0, sel}, 32'h1);
    drain("t7");
    check("t7_sel_idle", {27'd0, sel}, 32'h0);

    check("leftover_expected", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
